data_ram: RTL and testbench
===========================

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning word-address width; depth = 1 << ADDR_BITS words of 32 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port addr, input, ADDR_BITS+2, byte address; addr[ADDR_BITS+1:2] is the word index, addr[1:0] is the byte offset.
REQ-005 SHALL have port sel, input, 1, chip enable for both read and write.
REQ-006 SHALL have port we, input, 1, write enable; effective only with sel=1.
REQ-007 SHALL have port mode, input, 3, access size/sign: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101-111 treated as word.
REQ-008 SHALL have port din, input, 32, store data, right-aligned: byte in din[7:0], half in din[15:0].
REQ-009 SHALL have port dout, output, 32, load data, right-aligned and zero/sign extended per mode.
REQ-010 SHALL have port err, output, 1, misaligned-access flag, combinational.
REQ-011 SHALL have port busy, output, 1, registered; high while the memory is being cleared.

Function
REQ-012 SHALL store little-endian: byte offset k occupies word bits [8k+7:8k].
REQ-013 SHALL on a rising edge with sel=1, we=1, err=0, busy=0 write only the addressed lanes: word = all 4 lanes; half = lanes {1,0} when addr[1]=0, {3,2} when addr[1]=1; byte = lane addr[1:0].
REQ-014 SHALL leave unaddressed lanes of the word unchanged on partial writes.
REQ-015 SHALL drive dout combinationally with zero read latency: sel=0 or busy=1 -> 0; otherwise the addressed word/half/byte, extended per mode.
REQ-016 SHALL return write data on dout from the cycle after the writing edge; a same-cycle read returns the old contents.
REQ-017 SHALL assert err when sel=1 and (word mode with addr[1:0]!=00, or half mode with addr[0]=1); err=0 when sel=0.
REQ-018 SHALL suppress the write when err=1; dout is still driven, with the offending low address bits ignored: word-aligned for word mode, half-aligned for half mode.
REQ-019 SHALL ignore writes while busy=1; the dropped write has no later effect.
REQ-020 SHALL implement the clear sequencer as FSM IDLE/CLEAR with a word pointer ptr of ADDR_BITS bits (present only under REQ-026).
REQ-021 SHALL in CLEAR write 0 to mem[ptr] each edge, increment ptr, and go to IDLE on the edge that clears word (1<<ADDR_BITS)-1; ptr wraps to 0.

Reset
REQ-022 SHALL with rst=1 at an edge set state=CLEAR, ptr=0, busy=1 (macro defined) or busy=0 (macro undefined).
REQ-023 SHALL hold ptr at 0 while rst stays high; clearing proceeds only on edges with rst=0.
REQ-024 SHALL restart the clear from ptr=0 when rst is reasserted mid-clear.
REQ-025 SHALL leave dout and err purely combinational; they have no reset value beyond REQ-015.

Configuration
REQ-026 SHALL, with macro DATA_RAM_CLEAR_EN defined, implement REQ-020/021: busy deasserts exactly 1<<ADDR_BITS edges after rst deasserts, with all words then 0.
REQ-027 SHALL, with DATA_RAM_CLEAR_EN undefined, omit FSM and ptr, tie busy to 0, and leave memory contents untouched by rst; initial contents undefined.

Verification
REQ-028 SHALL cover clear: macro on, ADDR_BITS=4, rst 1 cycle -> busy=1 for exactly 16 edges, then every word reads 0x00000000.
REQ-029 SHALL cover lanes: SW 0x11223344 at 0x8, SB 0xAA at 0x9, SH 0xBEEF at 0xA -> LW 0x8 returns 0xBEEFAA44.
REQ-030 SHALL cover extension: word 0x80FF7F01 at 0x0 -> LB 0x3 = 0xFFFFFF80, LBU 0x3 = 0x00000080, LH 0x2 = 0xFFFF80FF, LHU 0x0 = 0x00007F01.
REQ-031 SHALL cover misalignment: SW 0xDEADBEEF at 0x6 -> err=1, word at 0x4 unchanged; LH at 0x1 -> err=1.
REQ-032 SHALL cover reset mid-clear: rst reasserted at ptr=7 -> ptr restarts at 0, busy high 16 more edges; SW during busy dropped, read 0.
REQ-033 SHALL cover macro off: write 0x12345678 at 0x4, pulse rst -> busy stays 0, LW 0x4 still 0x12345678.

Source files
------------

// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
//
// Byte-addressable, little-endian 32-bit data memory with zero-latency
// combinational reads and lane-masked synchronous writes. Loads are
// right-aligned and zero/sign extended according to the access mode.
// Misaligned word/half accesses raise err and suppress the store.
//
// Optional feature (macro DATA_RAM_CLEAR_EN):
//   defined   -> reset starts a clear sequencer that zeroes every word,
//                one word per clock, while busy is held high.
//   undefined -> no sequencer, busy is tied low and reset leaves the
//                memory contents alone.
//
// Parameters:
//   ADDR_BITS  word-address width; depth is (1 << ADDR_BITS) words
//
// Ports:
//   clk   in   single clock, all state changes on its rising edge
//   rst   in   synchronous active-high reset
//   addr  in   byte address: [ADDR_BITS+1:2] word index, [1:0] byte offset
//   sel   in   chip enable for reads and writes
//   we    in   write enable, qualified by sel
//   mode  in   000 word, 001 half unsigned, 010 half signed,
//              011 byte unsigned, 100 byte signed, 101-111 word
//   din   in   store data, right-aligned
//   dout  out  load data, right-aligned and extended (combinational)
//   err   out  misaligned-access flag (combinational)
//   busy  out  registered, high while the memory is being cleared
// ---------------------------------------------------------------------------
module data_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS+1:0] addr,
    input  logic                 sel,
    input  logic                 we,
    input  logic [2:0]           mode,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    output logic                 err,
    output logic                 busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [DEPTH];

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           byte_off;
    logic                 is_half;
    logic                 is_byte;
    logic                 is_word;
    logic                 is_signed;
    logic [31:0]          rd_word;
    logic [15:0]          rd_half;
    logic [7:0]           rd_byte;
    logic [3:0]           lane_en;
    logic [31:0]          wr_data;
    logic                 user_write;

    assign word_idx = addr[ADDR_BITS+1:2];
    assign byte_off = addr[1:0];

    // Classify the access. Unused mode codes fall through to word access.
    always_comb begin
        is_half   = (mode == 3'b001) || (mode == 3'b010);
        is_byte   = (mode == 3'b011) || (mode == 3'b100);
        is_word   = !is_half && !is_byte;
        is_signed = (mode == 3'b010) || (mode == 3'b100);
    end

    // Misalignment only matters when the chip is selected; byte accesses
    // can never be misaligned.
    assign err = sel && ((is_word && (byte_off != 2'b00)) ||
                         (is_half && byte_off[0]));

    // Read path. Half and byte selection only look at the address bits that
    // are meaningful for that size, so a misaligned access still returns
    // the aligned word/half it falls inside.
    always_comb begin
        rd_word = mem[word_idx];
        rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (byte_off)
            2'b00:   rd_byte = rd_word[7:0];
            2'b01:   rd_byte = rd_word[15:8];
            2'b10:   rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    // Output mux with extension. The bus is quiet when deselected or while
    // the clear sequencer owns the array.
    always_comb begin
        dout = 32'h0000_0000;
        if (sel && !busy) begin
            if (is_byte) begin
                dout = {{24{is_signed & rd_byte[7]}}, rd_byte};
            end else if (is_half) begin
                dout = {{16{is_signed & rd_half[15]}}, rd_half};
            end else begin
                dout = rd_word;
            end
        end
    end

    // Store data is replicated across lanes so the lane mask alone decides
    // which bytes of the word get written.
    always_comb begin
        lane_en = 4'b0000;
        wr_data = din;
        if (is_byte) begin
            lane_en = 4'b0001 << byte_off;
            wr_data = {4{din[7:0]}};
        end else if (is_half) begin
            lane_en = byte_off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{din[15:0]}};
        end else begin
            lane_en = 4'b1111;
            wr_data = din;
        end
    end

    assign user_write = sel && we && !err && !busy;

`ifdef DATA_RAM_CLEAR_EN

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    clr_state_t           state;
    logic [ADDR_BITS-1:0] ptr;
    logic                 clear_write;

    // Clear sequencer. Reset parks the pointer at word 0 and keeps it there
    // for as long as rst is held; each edge afterwards zeroes one word.
    // Leaving CLEAR happens on the edge that zeroes the last word, so busy
    // stays high for exactly DEPTH edges after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                end
                CLEAR: begin
                    ptr <= ptr + ADDR_BITS'(1);
                    if (ptr == {ADDR_BITS{1'b1}}) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clear_write = (state == CLEAR) && !rst;

    // Memory array. The sequencer and user stores never collide because
    // user stores are blocked whenever busy is high.
    always_ff @(posedge clk) begin
        if (clear_write) begin
            mem[ptr] <= 32'h0000_0000;
        end else if (user_write) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

`else

    logic unused_rst;

    // Without the sequencer there is nothing to reset; rst is accepted on
    // the port for interface compatibility only.
    assign unused_rst = rst;
    assign busy       = 1'b0;

    // Memory array with lane-masked user stores only.
    always_ff @(posedge clk) begin
        if (user_write) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_data_ram.sv
// ---------------------------------------------------------------------------
// tb_data_ram
//
// Self-checking bench for data_ram with ADDR_BITS=4. A byte-addressed
// reference memory (with a per-byte "known" flag) predicts err and dout.
// Works with DATA_RAM_CLEAR_EN either defined or undefined.
// ---------------------------------------------------------------------------
module tb_data_ram;

    localparam int AB     = 4;
    localparam int NWORDS = 1 << AB;
    localparam int NBYTES = 4 * NWORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic [AB+1:0] addr;
    logic          sel;
    logic          we;
    logic [2:0]    mode;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic          err;
    logic          busy;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [7:0] model_bytes [NBYTES];
    bit         model_known [NBYTES];

    typedef struct {
        logic          sel;
        logic          we;
        logic [2:0]    mode;
        logic [AB+1:0] addr;
        logic [31:0]   din;
        logic          chk_dout;
        logic [31:0]   exp_dout;
        logic          exp_err;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    data_ram #(.ADDR_BITS(AB)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .sel  (sel),
        .we   (we),
        .mode (mode),
        .din  (din),
        .dout (dout),
        .err  (err),
        .busy (busy)
    );

    // Reference model: access size in bytes for a mode code.
    function automatic int acc_size(input logic [2:0] m);
        case (m)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    function automatic bit model_err(input logic s, input logic [2:0] m, input logic [AB+1:0] a);
        return s && ((int'(a) % acc_size(m)) != 0);
    endfunction

    // Returns 1 when every byte the access touches has a known value.
    function automatic bit model_read(input logic s, input logic [2:0] m,
                                      input logic [AB+1:0] a, output logic [31:0] val);
        int  sz;
        int  base;
        bit  known;
        val = 32'h0;
        if (!s) return 1'b1;
        sz    = acc_size(m);
        base  = int'(a) - (int'(a) % sz);
        known = 1'b1;
        for (int i = 0; i < sz; i++) begin
            if (!model_known[base + i]) known = 1'b0;
            val[8*i +: 8] = model_bytes[base + i];
        end
        if (sz < 4 && (m == 3'd2 || m == 3'd4) && val[8*sz-1])
            val = val | (32'hFFFF_FFFF << (8*sz));
        return known;
    endfunction

    function automatic void model_write(input logic s, input logic w, input logic [2:0] m,
                                        input logic [AB+1:0] a, input logic [31:0] d,
                                        input logic busy_now);
        if (s && w && !model_err(s, m, a) && !busy_now) begin
            for (int i = 0; i < acc_size(m); i++) begin
                model_bytes[int'(a) + i] = d[8*i +: 8];
                model_known[int'(a) + i] = 1'b1;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) begin
            model_bytes[i] = 8'h00;
            model_known[i] = 1'b1;
        end
    endfunction

    task automatic applyStimulus(input logic s, input logic w, input logic [2:0] m,
                                 input logic [AB+1:0] a, input logic [31:0] d);
        sel  = s;
        we   = w;
        mode = m;
        addr = a;
        din  = d;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops, bounded so a stuck sequencer still
    // reaches the summary.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            sel = 1'b0;
            we  = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int w = 0; w < NWORDS; w++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, (AB+2)'(4*w), 32'h0);
            checkOutput($sformatf("%s word%0d", tag, w), dout, 32'h0000_0000);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, '0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        logic        s;
        logic        w;
        logic [2:0]  m;
        logic [AB+1:0] a;
        logic [31:0] d;
        logic [31:0] exp_val;
        bit          known;

        for (int i = 0; i < NBYTES; i++) begin
            model_bytes[i] = 8'h00;
            model_known[i] = 1'b0;
        end

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, '0, 32'h0);
        tick();

`ifdef DATA_RAM_CLEAR_EN
        checkOutput("busy after reset", 32'(busy), 32'd1);
        rst = 1'b0;
        count_busy(n);
        checkOutput("busy edges after reset", 32'(n), 32'd16);
        check_all_zero("cleared");
        model_clear();
`else
        rst = 1'b0;
        checkOutput("busy after reset", 32'(busy), 32'd0);
        tick();
        checkOutput("busy idle", 32'(busy), 32'd0);
`endif

        // sel, we, mode, addr, din, chk_dout, exp_dout, exp_err
        vecs.push_back('{1'b1, 1'b1, 3'd0, 6'h08, 32'h1122_3344, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd3, 6'h09, 32'h0000_00AA, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd1, 6'h0A, 32'h0000_BEEF, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 6'h08, 32'h0,         1'b1, 32'hBEEF_AA44, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 6'h00, 32'h80FF_7F01, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 6'h03, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 6'h03, 32'h0,         1'b1, 32'h0000_0080, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 6'h02, 32'h0,         1'b1, 32'hFFFF_80FF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 6'h00, 32'h0,         1'b1, 32'h0000_7F01, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 6'h04, 32'h0102_0304, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 6'h06, 32'hDEAD_BEEF, 1'b1, 32'h0102_0304, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 6'h04, 32'h0,         1'b1, 32'h0102_0304, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 6'h01, 32'h0,         1'b1, 32'h0000_7F01, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 6'h05, 32'h0,         1'b1, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 6'h08, 32'h0,         1'b1, 32'hBEEF_AA44, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 6'h0A, 32'h0000_0077, 1'b1, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 6'h08, 32'h0,         1'b1, 32'hBEEF_AA44, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 6'h08, 32'hCAFE_F00D, 1'b1, 32'hBEEF_AA44, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 6'h08, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 6'h0A, 32'h0,         1'b1, 32'hFFFF_CAFE, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 6'h09, 32'h0,         1'b1, 32'hFFFF_FFF0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].din);
            checkOutput($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].chk_dout)
                checkOutput($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
            model_write(vecs[i].sel, vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].din, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, '0, 32'h0);

`ifdef DATA_RAM_CLEAR_EN
        // Reset reasserted partway through a clear restarts it from word 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        checkOutput("busy mid-clear", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("busy after re-reset", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b1, 3'd0, 6'h3C, 32'h5555_5555);
        checkOutput("dout during busy", dout, 32'h0000_0000);
        count_busy(n);
        checkOutput("busy edges after re-reset", 32'(n), 32'd16);
        applyStimulus(1'b1, 1'b0, 3'd0, 6'h3C, 32'h0);
        checkOutput("dropped write", dout, 32'h0000_0000);
        check_all_zero("recleared");
        model_clear();
`else
        // Reset must not disturb memory contents without the sequencer.
        applyStimulus(1'b1, 1'b1, 3'd0, 6'h04, 32'h1234_5678);
        model_write(1'b1, 1'b1, 3'd0, 6'h04, 32'h1234_5678, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, '0, 32'h0);
        rst = 1'b1;
        tick();
        checkOutput("busy during rst", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("busy after rst pulse", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 6'h04, 32'h0);
        checkOutput("word kept over rst", dout, 32'h1234_5678);
`endif

        // Randomized traffic against the byte-level reference model.
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) != 0);
            w = 1'($urandom_range(0, 1));
            m = 3'($urandom_range(0, 7));
            a = (AB+2)'($urandom_range(0, NBYTES - 1));
            d = $urandom;
            applyStimulus(s, w, m, a, d);
            checkOutput($sformatf("rand%0d err", i), 32'(err), 32'(model_err(s, m, a)));
            known = model_read(s, m, a, exp_val);
            if (known)
                checkOutput($sformatf("rand%0d dout", i), dout, exp_val);
            if (i % 50 == 0)
                checkOutput($sformatf("rand%0d busy", i), 32'(busy), 32'd0);
            model_write(s, w, m, a, d, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, '0, 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
